// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port DMem arbiter (m0/m1 req,addr,wdata,read,write,mask,sext -> ack,rdata,err; mem_* latched command + valid, mem_rdata/mem_good back)
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [1:0]  m0_mask,
  input  logic        m0_sext,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [1:0]  m1_mask,
  input  logic        m1_sext,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_sext,
  output logic [1:0]  mem_mask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_good
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_d;
  logic [3:0] starve_cnt;
  logic port_q, err_q, pick1, bad, s_read, s_write;
  logic [31:0] rdata_q, s_addr;
  logic [1:0] s_mask;
  assign pick1 = m1_req & (~m0_req | starve_cnt == 4'(STARVE_LIMIT));
  assign s_addr = pick1 ? m1_addr : m0_addr;
  assign s_read = pick1 ? m1_read : m0_read;
  assign s_write = pick1 ? m1_write : m0_write;
  assign s_mask = pick1 ? m1_mask : m0_mask;
  assign bad = (s_read == s_write) | (s_mask == 2'b11) | (s_mask == 2'b01 & s_addr[0]) |
               (s_mask == 2'b10 & |s_addr[1:0]);
  always_comb begin
    state_d = IDLE;
    case (state)
      IDLE:    state_d = (m0_req | m1_req) ? (bad ? RESP : ACCESS) : IDLE;
      ACCESS:  state_d = RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      starve_cnt <= '0;
      port_q <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      mem_mask <= '0;
      mem_sext <= 1'b0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else if (state == IDLE && (m0_req | m1_req)) begin
      port_q <= pick1;
      mem_addr <= s_addr;
      mem_wdata <= pick1 ? m1_wdata : m0_wdata;
      mem_read <= s_read;
      mem_write <= s_write;
      mem_mask <= s_mask;
      mem_sext <= pick1 ? m1_sext : m0_sext;
      starve_cnt <= (pick1 | ~m1_req) ? 4'd0 :
                    (starve_cnt == 4'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + 4'd1;
      if (bad) err_q <= 1'b1;
    end else if (state == ACCESS) begin
      rdata_q <= mem_read ? mem_rdata : '0;
      err_q <= ~mem_good;
    end
  assign mem_valid = state == ACCESS;
  assign m0_ack = state == RESP & ~port_q;
  assign m1_ack = state == RESP & port_q;
  assign m0_rdata = rdata_q;
  assign m1_rdata = rdata_q;
  assign m0_err = err_q;
  assign m1_err = err_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: transaction-level model check of dmem_arbiter with a byte-array DMem
module tb_dmem_arbiter;
  localparam int LIM = 4;
  logic clk = 0, reset = 0;
  logic m0_req = 0, m0_read = 0, m0_write = 0, m0_sext = 0, m0_ack, m0_err;
  logic m1_req = 0, m1_read = 0, m1_write = 0, m1_sext = 0, m1_ack, m1_err;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m0_rdata, m1_addr = 0, m1_wdata = 0, m1_rdata;
  logic [1:0] m0_mask = 0, m1_mask = 0, mem_mask;
  logic mem_valid, mem_read, mem_write, mem_sext, mem_good = 1;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  int ncmp = 0, nfail = 0, cyc = 0;
  int ackq[$];
  int ackcyc[$];

  dmem_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_read(m0_read),
    .m0_write(m0_write), .m0_mask(m0_mask), .m0_sext(m0_sext),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_read(m1_read),
    .m1_write(m1_write), .m1_mask(m1_mask), .m1_sext(m1_sext),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_sext(mem_sext), .mem_mask(mem_mask),
    .mem_rdata(mem_rdata), .mem_good(mem_good)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DMem environment: little-endian byte array, combinational read, write at clock edge
  logic [7:0] dm [0:255];
  wire [7:0] ea = mem_addr[7:0];
  always_comb begin
    mem_rdata = {dm[ea + 8'd3], dm[ea + 8'd2], dm[ea + 8'd1], dm[ea]};
    if (mem_mask == 2'b00) mem_rdata = {{24{mem_sext & dm[ea][7]}}, dm[ea]};
    else if (mem_mask == 2'b01) mem_rdata = {{16{mem_sext & dm[ea + 8'd1][7]}}, dm[ea + 8'd1], dm[ea]};
  end
  always @(posedge clk)
    if (mem_valid && mem_write) begin
      dm[ea] <= mem_wdata[7:0];
      if (mem_mask != 2'b00) dm[ea + 8'd1] <= mem_wdata[15:8];
      if (mem_mask[1]) begin
        dm[ea + 8'd2] <= mem_wdata[23:16];
        dm[ea + 8'd3] <= mem_wdata[31:24];
      end
    end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ld(input logic [31:0] w, input logic [1:0] off, input logic [1:0] m, input logic s);
    logic [31:0] x;
    x = w >> (8 * int'(off));
    if (m == 2'b00) return s ? {{24{x[7]}}, x[7:0]} : {24'd0, x[7:0]};
    if (m == 2'b01) return s ? {{16{x[15]}}, x[15:0]} : {16'd0, x[15:0]};
    return w;
  endfunction

  function automatic logic [31:0] st(input logic [31:0] w, input logic [1:0] off, input logic [1:0] m, input logic [31:0] d);
    logic [31:0] r;
    int o;
    r = w;
    o = 8 * int'(off);
    if (m == 2'b00) r[o +: 8] = d[7:0];
    else if (m == 2'b01) r[o +: 16] = d[15:0];
    else r = d;
    return r;
  endfunction

  // Reference model: one transaction in flight, scheduled by cycle number
  logic [31:0] rm [0:63];
  logic busy = 0, t_port, t_legal, t_read, t_write, t_sext, t_err, g;
  logic [31:0] t_addr, t_wdata, t_rdata;
  logic [1:0] t_mask;
  int t_acc, t_ack, starve = 0;
  logic ev, ea0, ea1;
  always @(negedge clk) begin
    if (reset) begin
      busy = 0;
      starve = 0;
      chk("rst_mem_valid", mem_valid, 0);
      chk("rst_m0_ack", m0_ack, 0);
      chk("rst_m1_ack", m1_ack, 0);
      chk("rst_rdata", m0_rdata, 0);
      chk("rst_mem_addr", mem_addr, 0);
    end else begin
      ev = busy && t_legal && t_acc == cyc;
      ea0 = busy && t_ack == cyc && !t_port;
      ea1 = busy && t_ack == cyc && t_port;
      chk("mem_valid", mem_valid, ev);
      chk("m0_ack", m0_ack, ea0);
      chk("m1_ack", m1_ack, ea1);
      if (ev) begin
        chk("mem_addr", mem_addr, t_addr);
        chk("mem_write", mem_write, t_write);
        if (t_write) chk("mem_wdata", mem_wdata, t_wdata);
      end
      if (ea0 || ea1) begin
        chk("err", t_port ? m1_err : m0_err, t_err);
        if (t_legal) chk("rdata", t_port ? m1_rdata : m0_rdata, t_rdata);
      end
      if (m0_ack) begin ackq.push_back(0); ackcyc.push_back(cyc); end
      if (m1_ack) begin ackq.push_back(1); ackcyc.push_back(cyc); end
      if (ev) begin
        if (t_write) rm[t_addr[7:2]] = st(rm[t_addr[7:2]], t_addr[1:0], t_mask, t_wdata);
        t_rdata = t_write ? 0 : ld(rm[t_addr[7:2]], t_addr[1:0], t_mask, t_sext);
        t_err = !mem_good;
      end
      if (busy && t_ack == cyc) busy = 0;
      else if (!busy && (m0_req || m1_req)) begin
        g = m1_req && (!m0_req || starve == LIM);
        starve = (g || !m1_req) ? 0 : (starve < LIM ? starve + 1 : LIM);
        t_port = g;
        t_addr = g ? m1_addr : m0_addr;
        t_wdata = g ? m1_wdata : m0_wdata;
        t_read = g ? m1_read : m0_read;
        t_write = g ? m1_write : m0_write;
        t_mask = g ? m1_mask : m0_mask;
        t_sext = g ? m1_sext : m0_sext;
        t_legal = (t_read != t_write) && t_mask != 2'b11 &&
                  !(t_mask == 2'b01 && t_addr[0]) && !(t_mask == 2'b10 && t_addr[1:0] != 0);
        t_acc = cyc + 1;
        t_ack = t_legal ? cyc + 2 : cyc + 1;
        t_err = !t_legal;
        busy = 1;
      end
    end
  end

  task automatic txn(input int p, input logic [31:0] a, input logic [31:0] d, input logic r, input logic w,
                     input logic [1:0] m, input logic s, output logic [31:0] rd, output logic er, output int lat);
    int t0;
    logic got;
    @(posedge clk); #1;
    if (p == 0) begin
      m0_addr = a; m0_wdata = d; m0_read = r; m0_write = w; m0_mask = m; m0_sext = s; m0_req = 1;
    end else begin
      m1_addr = a; m1_wdata = d; m1_read = r; m1_write = w; m1_mask = m; m1_sext = s; m1_req = 1;
    end
    t0 = cyc;
    got = 0;
    rd = 0; er = 0; lat = -1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (p == 0 ? m0_ack : m1_ack) begin
        got = 1;
        rd = p == 0 ? m0_rdata : m1_rdata;
        er = p == 0 ? m0_err : m1_err;
        lat = cyc - t0;
      end
    end
    chk("ack_seen", got, 1);
    @(posedge clk); #1;
    if (p == 0) m0_req = 0;
    else m1_req = 0;
  endtask

  logic [31:0] rd;
  logic er;
  int lat, t0;
  int gexp[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  initial begin
    #1 reset = 1;
    #1;
    chk("reset_m0_ack", m0_ack, 0);
    chk("reset_m1_ack", m1_ack, 0);
    chk("reset_mem_valid", mem_valid, 0);
    chk("reset_mem_wdata", mem_wdata, 0);
    chk("reset_m1_err", m1_err, 0);
    repeat (2) @(posedge clk);
    #3 reset = 0;

    txn(0, 32'h10, 32'hDEADBEEF, 0, 1, 2'b10, 0, rd, er, lat);
    chk("wr_latency", lat, 2); chk("wr_err", er, 0);
    txn(0, 32'h10, 0, 1, 0, 2'b10, 0, rd, er, lat);
    chk("rd_latency", lat, 2); chk("rd_data", rd, 32'hDEADBEEF); chk("rd_err", er, 0);

    txn(0, 32'h10, 32'h80000000, 0, 1, 2'b10, 0, rd, er, lat);
    txn(1, 32'h13, 0, 1, 0, 2'b00, 1, rd, er, lat);
    chk("lb_sext", rd, 32'hFFFFFF80);
    txn(1, 32'h13, 0, 1, 0, 2'b00, 0, rd, er, lat);
    chk("lb_zext", rd, 32'h00000080);
    txn(0, 32'h12, 0, 1, 0, 2'b01, 1, rd, er, lat);
    chk("lh_sext", rd, 32'hFFFF8000);

    txn(0, 32'h20, 0, 1, 1, 2'b10, 0, rd, er, lat);
    chk("ill_rw_err", er, 1); chk("ill_rw_lat", lat, 1);
    txn(1, 32'h20, 0, 0, 0, 2'b10, 0, rd, er, lat);
    chk("ill_none_err", er, 1); chk("ill_none_lat", lat, 1);
    txn(1, 32'h21, 0, 1, 0, 2'b01, 0, rd, er, lat);
    chk("ill_half_err", er, 1); chk("ill_half_lat", lat, 1);
    txn(0, 32'h22, 0, 0, 1, 2'b10, 0, rd, er, lat);
    chk("ill_word_err", er, 1); chk("ill_word_lat", lat, 1);
    txn(1, 32'h20, 0, 1, 0, 2'b11, 0, rd, er, lat);
    chk("ill_mask_err", er, 1); chk("ill_mask_lat", lat, 1);

    mem_good = 0;
    txn(1, 32'h10, 0, 1, 0, 2'b10, 0, rd, er, lat);
    chk("bad_mem_err", er, 1);
    mem_good = 1;

    // both ports request continuously
    @(posedge clk); #1;
    m0_addr = 32'h10; m0_read = 1; m0_write = 0; m0_mask = 2'b10; m0_sext = 0;
    m1_addr = 32'h10; m1_read = 1; m1_write = 0; m1_mask = 2'b10; m1_sext = 0;
    ackq.delete();
    m0_req = 1; m1_req = 1;
    for (int i = 0; i < 60 && ackq.size() < 10; i++) @(posedge clk);
    #1 m0_req = 0; m1_req = 0;
    chk("starve_count", ackq.size(), 10);
    for (int i = 0; i < 10 && i < ackq.size(); i++) chk($sformatf("grant_%0d", i), ackq[i], gexp[i]);

    // port 0 holds req across its ack
    @(posedge clk); #1;
    ackq.delete(); ackcyc.delete();
    m0_req = 1;
    t0 = cyc;
    for (int i = 0; i < 20 && ackq.size() < 2; i++) @(posedge clk);
    #1 m0_req = 0;
    chk("hold_count", ackq.size(), 2);
    if (ackq.size() >= 2) begin
      chk("hold_ack1", ackcyc[0] - t0, 2);
      chk("hold_ack2", ackcyc[1] - t0, 5);
    end

    // reset in the middle of a write
    txn(0, 32'h30, 32'hAAAAAAAA, 0, 1, 2'b10, 0, rd, er, lat);
    @(posedge clk); #1;
    m0_addr = 32'h30; m0_wdata = 32'h12345678; m0_read = 0; m0_write = 1; m0_mask = 2'b10; m0_req = 1;
    @(posedge clk); #2;
    chk("abort_valid_pre", mem_valid, 1);
    reset = 1;
    #1;
    chk("abort_valid", mem_valid, 0);
    chk("abort_addr", mem_addr, 0);
    chk("abort_wdata", mem_wdata, 0);
    chk("abort_ack", m0_ack, 0);
    m0_req = 0;
    repeat (2) @(posedge clk);
    #3 reset = 0;
    txn(0, 32'h30, 0, 1, 0, 2'b10, 0, rd, er, lat);
    chk("abort_readback", rd, 32'hAAAAAAAA);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
